// File: rtl/nios_audio_i2c_master.sv
// Avalon-MM I2C byte master for the audio codec: each command runs an optional START,
// one byte write or read with its ACK slot, an optional STOP, then raises DONE.
module nios_audio_i2c_master #(
  parameter int unsigned DEFAULT_DIV = 124
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
  } state_e;

  localparam int C_START = 0;
  localparam int C_STOP  = 1;
  localparam int C_WR    = 2;
  localparam int C_RD    = 3;
  localparam int C_ACKO  = 4;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q;
  logic [7:0]  txdata_q, rxdata_q, shift_q;
  logic [4:0]  cmd_q;
  logic [15:0] clkdiv_q;
  logic        ien_q, rx_ack_q, busy_q, done_q;
  logic [31:0] readdata_q;

  logic wr_en, cmd_acc, wr_mode, rd_mode, term, stall, tick, step, sample;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign wr_en   = chipselect & ~write_n;
  assign cmd_acc = wr_en && (address == 2'd1) && !busy_q;
  assign wr_mode = cmd_q[C_WR];
  assign rd_mode = cmd_q[C_RD] & ~cmd_q[C_WR];
  assign term    = (cnt_q == clkdiv_q);
  // A slave holding SCL low while we have released it freezes the phase timer
  assign stall   = ((state_q == S_BIT) || (state_q == S_ACK) || (state_q == S_STOP)) &&
                   ((phase_q == 2'd1) || (phase_q == 2'd2)) && !scl_in && !scl_oe;
  assign tick    = term && !stall;
  assign step    = tick && (phase_q == 2'd3);
  assign sample  = tick && (phase_q == 2'd2);

  function automatic state_e after_start(input logic [4:0] c);
    if (c[C_WR] || c[C_RD]) return S_BIT;
    if (c[C_STOP])          return S_STOP;
    return S_DONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_acc) state_d = writedata[C_START] ? S_START : after_start(writedata[4:0]);
      S_START: if (step) state_d = after_start(cmd_q);
      S_BIT:   if (step && (bitcnt_q == 3'd7)) state_d = S_ACK;
      S_ACK:   if (step) state_d = cmd_q[C_STOP] ? S_STOP : S_DONE;
      S_STOP:  if (step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        sda_oe = phase_q[1];
        scl_oe = (phase_q == 2'd3);
      end
      S_BIT: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = wr_mode & ~shift_q[7];
      end
      S_ACK: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = rd_mode & ~cmd_q[C_ACKO];
      end
      S_STOP: begin
        scl_oe = (phase_q == 2'd0);
        sda_oe = ~phase_q[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else if (!stall) begin
      cnt_d   = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      txdata_q   <= '0;
      rxdata_q   <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      clkdiv_q   <= DEFAULT_DIV[15:0];
      ien_q      <= 1'b0;
      rx_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (wr_en && (address == 2'd0) && !busy_q) txdata_q <= writedata[7:0];
      if (wr_en && (address == 2'd3) && !busy_q) clkdiv_q <= writedata[15:0];
      if (wr_en && (address == 2'd2)) ien_q <= writedata[3];
      if (cmd_acc) begin
        cmd_q   <= writedata[4:0];
        shift_q <= txdata_q;
        busy_q  <= 1'b1;
      end else if (state_q == S_DONE) begin
        busy_q  <= 1'b0;
      end
      // Setting DONE outranks a same-cycle W1C
      if (state_q == S_DONE) done_q <= 1'b1;
      else if (wr_en && (address == 2'd2) && writedata[0]) done_q <= 1'b0;
      if ((state_q == S_BIT) && step) begin
        bitcnt_q <= bitcnt_q + 3'd1;
        shift_q  <= {shift_q[6:0], 1'b0};
      end
      if ((state_q == S_BIT) && sample && rd_mode) rxdata_q <= {rxdata_q[6:0], sda_in};
      if ((state_q == S_ACK) && sample && wr_mode) rx_ack_q <= sda_in;
      case (address)
        2'd0:    readdata_q <= {24'd0, rxdata_q};
        2'd1:    readdata_q <= {27'd0, cmd_q};
        2'd2:    readdata_q <= {28'd0, ien_q, rx_ack_q, busy_q, done_q};
        default: readdata_q <= {16'd0, clkdiv_q};
      endcase
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q & ien_q;

endmodule

// File: tb/tb_nios_audio_i2c_master.sv
// Bench for nios_audio_i2c_master: bus-level slave/monitor plus a byte-level model
// of what each command should put on the wires and in the registers.
module tb_nios_audio_i2c_master;
  localparam int DEF_DIV = 124;

  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq, scl_in, sda_in, scl_oe, sda_oe;

  int checks = 0, failures = 0;

  // slave / monitor state (written only by the negedge process below)
  logic slave_bit = 1'b1, stretch_req = 1'b0, scl_p = 1'b0, sda_p = 1'b0;
  int   cyc = 0, fall_cnt = 0, start_cnt = 0, stop_cnt = 0, stretch_left = 0, slv_idx = 0;
  int   rises[$];
  logic bits[$];
  // controls written only by the stimulus process
  logic       slv_arm = 1'b0, mon_clr = 1'b0, slv_ack = 1'b1;
  logic [7:0] slv_byte = 8'hFF;
  int         stretch_at = -1;
  // model state
  logic [7:0] exp_rx = 8'h00;
  logic       exp_rxack = 1'b0, ien_tb = 1'b0;

  assign scl_in = ~scl_oe & ~stretch_req;
  assign sda_in = ~sda_oe & slave_bit;

  always #5 clk = ~clk;

  nios_audio_i2c_master #(.DEFAULT_DIV(DEF_DIV)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always @(negedge clk) begin
    cyc++;
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) stretch_req = 1'b0;
    end
    if (mon_clr) begin
      rises.delete(); bits.delete();
      fall_cnt = 0; start_cnt = 0; stop_cnt = 0;
    end else begin
      if (scl_oe && !scl_p) rises.push_back(cyc);
      if (!scl_oe && scl_p) begin
        bits.push_back(sda_oe);
        fall_cnt++;
        if (fall_cnt == stretch_at) begin stretch_req = 1'b1; stretch_left = 20; end
      end
      if (!scl_oe && !scl_p && sda_oe && !sda_p) start_cnt++;
      if (!scl_oe && !scl_p && !sda_oe && sda_p) stop_cnt++;
    end
    if (slv_arm) begin
      slv_idx = 0; slave_bit = 1'b1;
    end else if (scl_oe && !scl_p) begin
      slave_bit = (slv_idx < 8) ? slv_byte[7-slv_idx] : ((slv_idx == 8) ? slv_ack : 1'b1);
      slv_idx++;
    end
    scl_p = scl_oe;
    sda_p = sda_oe;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); address = a;
    @(negedge clk); d = readdata;
  endtask

  task automatic prep_slave(input logic [7:0] b, input logic a);
    @(posedge clk); slv_byte = b; slv_ack = a; slv_arm = 1'b1; mon_clr = 1'b1;
    @(posedge clk); slv_arm = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    @(negedge clk); address = 2'd2;
    @(negedge clk);
    while (!readdata[0] && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (readdata[0] !== 1'b1) begin
      failures++; $display("FAIL %s_done_timeout status=%h required done=1", nm, readdata);
    end
  endtask

  // Run one command and compare wires and registers with the byte-level model.
  task automatic do_xfer(input string nm, input logic [4:0] cmd, input logic [7:0] tx,
                         input logic [15:0] div, input logic [7:0] sbyte, input logic sack,
                         input int stretch_k, input bit poke);
    logic start, stop, wr, rd, xfer;
    logic [7:0] oe_v, exp_oe;
    logic [31:0] rv;
    int exp_iv;
    start = cmd[0]; stop = cmd[1]; wr = cmd[2]; rd = cmd[3] & ~cmd[2]; xfer = cmd[2] | cmd[3];
    bus_write(2'd3, {16'd0, div});
    bus_write(2'd0, {24'd0, tx});
    bus_write(2'd2, {28'd0, ien_tb, 3'b001});
    stretch_at = (stretch_k < 0) ? -1 : stretch_k + 1;
    prep_slave(wr ? 8'hFF : sbyte, rd ? 1'b1 : sack);
    bus_write(2'd1, {27'd0, cmd});
    if (poke) begin
      bus_write(2'd1, 32'h1A);
      bus_write(2'd3, 32'h0);
      bus_read(2'd1, rv);
      checks++; if (rv !== {27'd0, cmd}) begin failures++; $display("FAIL %s_busy_cmd got=%h exp=%h", nm, rv, cmd); end
      bus_read(2'd3, rv);
      checks++; if (rv !== {16'd0, div}) begin failures++; $display("FAIL %s_busy_div got=%h exp=%h", nm, rv, div); end
    end
    wait_done(nm);
    stretch_at = -1;
    if (rd) exp_rx = sbyte;
    if (wr) exp_rxack = sack;
    bus_read(2'd0, rv);
    checks++; if (rv !== {24'd0, exp_rx}) begin failures++; $display("FAIL %s_rxdata got=%h exp=%h", nm, rv, exp_rx); end
    bus_read(2'd2, rv);
    checks++; if (rv !== {28'd0, ien_tb, exp_rxack, 2'b01}) begin failures++; $display("FAIL %s_status got=%h exp=%h", nm, rv, {ien_tb, exp_rxack, 2'b01}); end
    bus_read(2'd1, rv);
    checks++; if (rv !== {27'd0, cmd}) begin failures++; $display("FAIL %s_cmd_rb got=%h exp=%h", nm, rv, cmd); end
    checks++; if (irq !== ien_tb) begin failures++; $display("FAIL %s_irq got=%b exp=%b", nm, irq, ien_tb); end
    checks++; if (start_cnt !== int'(start)) begin failures++; $display("FAIL %s_starts got=%0d exp=%0d", nm, start_cnt, start); end
    checks++; if (stop_cnt !== int'(stop)) begin failures++; $display("FAIL %s_stops got=%0d exp=%0d", nm, stop_cnt, stop); end
    if (xfer) begin
      checks++;
      if (bits.size() < 9 || rises.size() < 10) begin
        failures++; $display("FAIL %s_edge_count bits=%0d rises=%0d exp>=9,10", nm, bits.size(), rises.size());
      end else begin
        for (int i = 0; i < 8; i++) oe_v[7-i] = bits[i];
        exp_oe = wr ? ~tx : 8'h00;
        checks++; if (oe_v !== exp_oe) begin failures++; $display("FAIL %s_sda_bits got=%h exp=%h", nm, oe_v, exp_oe); end
        checks++; if (bits[8] !== (rd & ~cmd[4])) begin failures++; $display("FAIL %s_ack_sda got=%b exp=%b", nm, bits[8], rd & ~cmd[4]); end
        for (int j = 1; j <= 8; j++) begin
          exp_iv = 4 * (int'(div) + 1) + ((j == stretch_k) ? 20 : 0);
          checks++;
          if (rises[j+1] - rises[j] !== exp_iv) begin
            failures++; $display("FAIL %s_bit_len[%0d] got=%0d exp=%0d", nm, j, rises[j+1] - rises[j], exp_iv);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rv;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin failures++; $display("FAIL reset_lines got=%b%b exp=00", scl_oe, sda_oe); end
    checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset = 1'b0;
    bus_read(2'd3, rv);
    checks++; if (rv !== DEF_DIV) begin failures++; $display("FAIL reset_clkdiv got=%0d exp=%0d", rv, DEF_DIV); end
    for (int a = 0; a < 3; a++) begin
      bus_read(a[1:0], rv);
      checks++; if (rv !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", a, rv); end
    end
  endtask

  task automatic test_write_ack();
    do_xfer("wr_ack", 5'b00101, 8'h34, 16'd3, 8'h00, 1'b0, -1, 1'b0);
  endtask

  task automatic test_read();
    do_xfer("rd_stop", 5'b11010, 8'h00, 16'd3, 8'hA5, 1'b1, -1, 1'b0);
  endtask

  task automatic test_stretch();
    do_xfer("stretch", 5'b00101, 8'h5A, 16'd3, 8'h00, 1'b0, 3, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_xfer("busy", 5'b00101, 8'h34, 16'd3, 8'h00, 1'b0, -1, 1'b1);
  endtask

  task automatic test_empty_cmds();
    do_xfer("empty", 5'b00000, 8'h00, 16'd2, 8'h00, 1'b0, -1, 1'b0);
    do_xfer("start_stop", 5'b00011, 8'h00, 16'd0, 8'h00, 1'b0, -1, 1'b0);
  endtask

  task automatic test_nack_irq();
    logic [31:0] rv;
    ien_tb = 1'b1;
    bus_write(2'd2, 32'h8);
    do_xfer("nack", 5'b00111, 8'hC3, 16'd1, 8'h00, 1'b1, -1, 1'b0);
    bus_write(2'd2, 32'h9);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL nack_irq_clear got=%b exp=0", irq); end
    bus_read(2'd2, rv);
    checks++; if (rv !== 32'hC) begin failures++; $display("FAIL nack_status_after_w1c got=%h exp=c", rv); end
    ien_tb = 1'b0;
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_random();
    logic [4:0] c;
    for (int k = 0; k < 8; k++) begin
      c = 5'($urandom_range(0, 31));
      do_xfer("rand", c, 8'($urandom), 16'($urandom_range(0, 4)), 8'($urandom),
              1'($urandom), -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rv;
    int n = 0;
    bus_write(2'd3, 32'd3);
    bus_write(2'd0, 32'h96);
    bus_write(2'd2, 32'h1);
    prep_slave(8'hFF, 1'b0);
    bus_write(2'd1, 32'h7);
    while (!(fall_cnt >= 3 && scl_oe) && n < 2000) begin @(negedge clk); n++; end
    checks++; if (fall_cnt < 3) begin failures++; $display("FAIL midrst_wait got=%0d exp>=3", fall_cnt); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin failures++; $display("FAIL midrst_lines got=%b%b exp=00", scl_oe, sda_oe); end
    reset = 1'b0;
    exp_rx = 8'h00; exp_rxack = 1'b0; ien_tb = 1'b0;
    bus_read(2'd2, rv);
    checks++; if (rv !== 32'd0) begin failures++; $display("FAIL midrst_status got=%h exp=0", rv); end
    bus_read(2'd3, rv);
    checks++; if (rv !== DEF_DIV) begin failures++; $display("FAIL midrst_clkdiv got=%0d exp=%0d", rv, DEF_DIV); end
    repeat (50) @(negedge clk);
    checks++; if (stop_cnt !== 0) begin failures++; $display("FAIL midrst_no_stop got=%0d exp=0", stop_cnt); end
    do_xfer("after_rst", 5'b01011, 8'h00, 16'd2, 8'h3C, 1'b1, -1, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_stretch();
    test_busy_ignore();
    test_empty_cmds();
    test_nack_irq();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_audio_i2c_master.md
NIOS_AUDIO_I2C_MASTER -- requirements
Module: nios_audio_i2c_master

Interface
REQ-001 SHALL have parameter: DEFAULT_DIV, 124, reset value of CLKDIV register (phase length = CLKDIV+1 clk cycles).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: address  input  2  Avalon-MM register select.
REQ-005 SHALL have port: chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port: write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 SHALL have port: writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port: readdata  output  32  registered read data, zero-extended.
REQ-009 SHALL have port: irq  output  1  interrupt, DONE & IEN.
REQ-010 SHALL have port: scl_in  input  1  sampled SCL line level.
REQ-011 SHALL have port: sda_in  input  1  sampled SDA line level.
REQ-012 SHALL have port: scl_oe  output  1  1 = pull SCL low, 0 = release.
REQ-013 SHALL have port: sda_oe  output  1  1 = pull SDA low, 0 = release.

Function
REQ-014 SHALL update readdata every cycle from address: 0 RXDATA[7:0]; 1 last CMD[4:0]; 2 {IEN,RX_ACK,BUSY,DONE}; 3 CLKDIV[15:0].
REQ-015 SHALL accept writes (chipselect & ~write_n): addr 0 TXDATA[7:0]; addr 1 CMD bits START0 STOP1 WR2 RD3 ACK_OUT4; addr 2 bit0=1 clears DONE, bit3 writes IEN; addr 3 CLKDIV[15:0].
REQ-016 SHALL ignore writes to addr 0, 1, 3 while BUSY=1; addr 2 writes always take effect.
REQ-017 SHALL set BUSY the cycle after an accepted CMD write and leave IDLE on that cycle.
REQ-018 SHALL use FSM states IDLE, START, BIT, ACK, STOP, DONE; sequence START (if START bit) -> 8 x BIT -> ACK (if WR or RD) -> STOP (if STOP bit) -> DONE -> IDLE.
REQ-019 SHALL treat WR and RD both set as WR only; CMD with no bits set goes IDLE -> DONE -> IDLE.
REQ-020 SHALL divide each state/bit into 4 phases; phase counter counts 0..CLKDIV, advances phase on terminal count, reloads 0; held at 0 in IDLE.
REQ-021 SHALL in BIT/ACK: ph0 SCL low, set SDA; ph1 release SCL; ph2 SCL high, sample sda_in at ph2 terminal count; ph3 SCL low.
REQ-022 SHALL in START: ph0-1 both released, ph2 SDA low, ph3 SCL low; STOP: ph0 SCL low SDA low, ph1 SCL released, ph2-3 SDA released.
REQ-023 SHALL stretch: in ph1/ph2 of BIT, ACK, STOP, hold phase counter while scl_in=0 and scl_oe=0.
REQ-024 SHALL for WR shift TXDATA MSB first (sda_oe = ~bit), release SDA in ACK and store sampled level in RX_ACK (1 = NACK).
REQ-025 SHALL for RD release SDA for 8 bits, shift samples MSB first into RXDATA, drive sda_oe = ~ACK_OUT in ACK.
REQ-026 SHALL in DONE set DONE=1, clear BUSY, release both lines; DONE sticky until W1C; W1C and set same cycle -> set wins.
REQ-027 SHALL release scl_oe and sda_oe in IDLE and DONE.
REQ-028 SHALL treat CLKDIV=0 as 1-cycle phases (no stall).

Reset
REQ-029 SHALL on reset: FSM IDLE, scl_oe=0, sda_oe=0, readdata=0, irq=0, BUSY=0, DONE=0, IEN=0, RX_ACK=0, TXDATA=RXDATA=CMD=0, CLKDIV=DEFAULT_DIV, phase counter 0.
REQ-030 SHALL honour reset mid-transfer: lines released the cycle after reset sampled high, no STOP generated.

Verification
REQ-031 SHALL cover: reset held 2 cycles -> scl_oe=sda_oe=0, readdata=0, addr 3 reads DEFAULT_DIV.
REQ-032 SHALL cover: CLKDIV=3, TXDATA=0x34, CMD=START|WR, slave drives ACK 0 -> SDA bits 0,0,1,1,0,1,0,0, each bit 16 clk, RX_ACK=0, DONE=1.
REQ-033 SHALL cover: CMD=RD|ACK_OUT|STOP, slave drives 0xA5 -> RXDATA=0xA5, sda_oe=0 through ACK, STOP seen, then IDLE.
REQ-034 SHALL cover: scl_in held 0 for 20 cycles in ph1 -> bit lengthened by exactly 20 cycles.
REQ-035 SHALL cover: CMD write while BUSY -> ignored, transfer unchanged; reset mid-byte -> lines released next cycle, BUSY=0.
REQ-036 SHALL cover: IEN=1, slave NACK -> RX_ACK=1, irq=1 after DONE; write addr2 bit0=1 -> irq=0 next cycle.
